// File: rtl/sched_req_queue.sv
// Per-source request FIFOs feeding a round-robin scheduler; the granted FIFO
// is popped into a single registered output slot with valid/ready handshake.
module sched_req_queue #(
    parameter int LG_N = 2,
    parameter int LG_D = 2,
    parameter int W    = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [(1<<LG_N)-1:0]     in_valid,
    output logic [(1<<LG_N)-1:0]     in_ready,
    input  logic [(1<<LG_N)*W-1:0]   in_data,
    output logic [(1<<LG_N)-1:0]     req,
    input  logic [LG_N:0]            gnt,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [W-1:0]             out_data,
    output logic [LG_N-1:0]          out_src
);
    localparam int N = 1 << LG_N;
    localparam int D = 1 << LG_D;
    localparam logic [LG_D:0] PTR_ONE = (LG_D+1)'(1);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [N-1:0][LG_D:0] head, tail;
    logic [W-1:0]         mem [N*D];

    logic [N-1:0]    full, empty, push;
    logic [LG_N-1:0] g;
    logic            fire;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        full  = '0;
        empty = '0;
        for (int i = 0; i < N; i++) begin
            empty[i] = (head[i] == tail[i]);
            full[i]  = (head[i][LG_D-1:0] == tail[i][LG_D-1:0]) &&
                       (head[i][LG_D] != tail[i][LG_D]);
        end
    end

    assign in_ready = ~full;
    assign req      = ~empty;
    assign push     = in_valid & in_ready;
    assign g        = gnt[LG_N-1:0];
    assign fire     = !gnt[LG_N] && req[g] && (!out_valid || out_ready);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head <= '0;
            tail <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (push[i]) tail[i] <= tail[i] + PTR_ONE;
                if (fire && (g == LG_N'(i))) head[i] <= head[i] + PTR_ONE;
            end
        end
    end

    // NOTE: storage is deliberately not reset; clearing the pointers already discards the contents.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (push[i]) mem[{LG_N'(i), tail[i][LG_D-1:0]}] <= in_data[i*W +: W];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
        end else if (fire) begin
            out_valid <= 1'b1;
            out_data  <= mem[{g, head[g][LG_D-1:0]}];
            out_src   <= g;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // A grant to an empty source is a scheduler bug; stop simulation loudly.
    assert property (@(posedge clk) disable iff (!rst_n) gnt[LG_N] || req[g])
        else $fatal(1, "grant to empty source: gnt=%b req=%b", gnt, req);

endmodule
